// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: next-PC select encoding, fetch FSM states,
// the canonical NOP and the default reset PC.
package rv32i_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_JAL  = 2'b01,
    NPC_BR   = 2'b10,
    NPC_JALR = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    REQ   = 2'b00,
    WAIT  = 2'b01,
    HOLD  = 2'b10,
    FAULT = 2'b11
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Purely combinational next-PC selection for the fetch stage.
// Produces the raw target; alignment policy is applied by the caller.
module next_pc_calc
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr_pc,
  input  logic [1:0]      n_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;

  // Both adders wrap modulo 2^XLEN by construction.
  assign seq_pc = instr_pc + XLEN'(4);
  assign rel_pc = instr_pc + imm;

  // Select the target for the retiring instruction; JALR clears bit 0.
  always_comb begin
    next_pc = seq_pc;
    unique case (npc_sel_e'(n_pc))
      NPC_SEQ:  next_pc = seq_pc;
      NPC_JAL:  next_pc = rel_pc;
      NPC_BR:   next_pc = branch_taken ? rel_pc : seq_pc;
      NPC_JALR: next_pc = alu_result & ~XLEN'(1);
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues one request at a time
// over a valid/ready handshake, holds the fetched word until retire.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned
// next PC instead of silently aligning it).
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  input  logic            retire,
  input  logic [1:0]      n_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            fetch_fault
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_load;
  logic            misaligned;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
    .instr_pc     (instr_pc),
    .n_pc         (n_pc),
    .branch_taken (branch_taken),
    .imm          (imm),
    .alu_result   (alu_result),
    .next_pc      (next_pc)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  // Keep the raw target so a debugger can see where the bad jump went.
  assign pc_load    = next_pc;
  assign misaligned = (next_pc[1:0] != 2'b00);
`else
  assign pc_load    = next_pc & ~XLEN'(3);
  assign misaligned = 1'b0;
`endif

  assign imem_addr = pc;
  assign pc_plus4  = instr_pc + XLEN'(4);

  // Fetch FSM: request, wait for data, hold until retire (or trap).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= REQ;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      instr          <= NOP_INSTR;
      instr_valid    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault    <= 1'b0;
`endif
    end else begin
      unique case (state)
        REQ: begin
          // The request is raised one edge after reset; the grant needs it up.
          if (imem_req_valid && imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (retire) begin
            instr_valid <= 1'b0;
            pc          <= pc_load;
            if (misaligned) begin
              state <= FAULT;
`ifdef FETCH_MISALIGN_TRAP_EN
              fetch_fault <= 1'b1;
`endif
            end else begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end
          end
        end
        FAULT: begin
          // Sticky until reset; no further requests.
          state <= FAULT;
        end
      endcase
    end
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = 1'b0;
`endif

  // PC of the held instruction, captured alongside the instruction word.
  always_ff @(posedge clk) begin
    if (state == WAIT && imem_rsp_valid) begin
      instr_pc <= pc;
    end
  end

endmodule
